// File: rtl/bat_bus_pkg.sv
// Shared definitions for the Bat Amateur bus sequencer: opcodes, state encoding
// and small opcode-classification helpers.
package bat_bus_pkg;

    localparam int MAX_REGS = 16;

    localparam logic [1:0] OP_MOVE     = 2'd0;
    localparam logic [1:0] OP_LOAD_IMM = 2'd1;
    localparam logic [1:0] OP_READ     = 2'd2;
    localparam logic [1:0] OP_INC      = 2'd3;

    // Direction of every register while it is not enabled: "drive" side, never latching.
    localparam logic [MAX_REGS-1:0] IDLE_RW = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LATCH,
        ST_INC,
        ST_ERR,
        ST_RDONE
    } seq_state_e;

    function automatic logic op_uses_src(input logic [1:0] op);
        return (op == OP_MOVE) || (op == OP_READ);
    endfunction

    function automatic logic op_uses_dst(input logic [1:0] op);
        return op != OP_READ;
    endfunction

    function automatic logic op_writes_reg(input logic [1:0] op);
        return (op == OP_MOVE) || (op == OP_LOAD_IMM);
    endfunction

endpackage

// File: rtl/bus_index_decoder.sv
// Register index to one-hot strobe decoder; also reports whether the index
// names an attached register at all.
module bus_index_decoder #(
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic [SEL_W-1:0]    i_sel,
    input  logic                i_en,
    output logic [NUM_REGS-1:0] o_onehot,
    output logic                o_in_range
);

    always_comb begin
        // NOTE: every output gets a default before the loop, otherwise the
        // untouched bits would hold their value and infer latches.
        o_in_range = 1'b0;
        o_onehot   = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_in_range  = 1'b1;
                o_onehot[k] = i_en;
            end
        end
    end

endmodule

// File: rtl/bus_sequencer.sv
// Bus initiator: accepts one command at a time and sequences the per-register
// ENABLE/RW/COUNT strobes and the immediate drive on the shared DATA bus.
module bus_sequencer
    import bat_bus_pkg::*;
#(
    parameter int BUS_WIDTH = 16,
    parameter int NUM_REGS  = 8,
    parameter int SEL_W     = $clog2(NUM_REGS)
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 CMD_VALID,
    output logic                 CMD_READY,
    input  logic [1:0]           CMD_OP,
    input  logic [SEL_W-1:0]     CMD_SRC,
    input  logic [SEL_W-1:0]     CMD_DST,
    input  logic [BUS_WIDTH-1:0] CMD_IMM,
    output logic [NUM_REGS-1:0]  ENABLE,
    output logic [NUM_REGS-1:0]  RW,
    output logic [NUM_REGS-1:0]  COUNT,
    inout  wire  [BUS_WIDTH-1:0] DATA,
    output logic [BUS_WIDTH-1:0] RDATA,
    output logic                 RDATA_VALID,
    output logic                 ERROR
);

    seq_state_e           r_state;
    seq_state_e           w_next_state;
    logic [1:0]           r_op;
    logic [SEL_W-1:0]     r_src;
    logic [SEL_W-1:0]     r_dst;
    logic [BUS_WIDTH-1:0] r_imm;
    logic [BUS_WIDTH-1:0] r_rdata;

    logic                 w_idle;
    logic                 w_accept;
    logic                 w_reject;
    logic [SEL_W-1:0]     w_src_sel;
    logic [SEL_W-1:0]     w_dst_sel;
    logic                 w_src_en;
    logic                 w_dst_en;
    logic [NUM_REGS-1:0]  w_src_oh;
    logic [NUM_REGS-1:0]  w_dst_oh;
    logic                 w_src_in_range;
    logic                 w_dst_in_range;
    logic [NUM_REGS-1:0]  w_dst_wr_oh;
    logic                 w_drive_data;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = CMD_VALID && CMD_READY;

    // In IDLE the decoders look at the incoming command for the range check;
    // afterwards they decode the latched indices into strobes.
    assign w_src_sel = w_idle ? CMD_SRC : r_src;
    assign w_dst_sel = w_idle ? CMD_DST : r_dst;
    assign w_src_en  = ((r_state == ST_SETUP) || (r_state == ST_LATCH)) && op_uses_src(r_op);
    assign w_dst_en  = ((r_state == ST_LATCH) && op_writes_reg(r_op)) || (r_state == ST_INC);

    bus_index_decoder #(
        .NUM_REGS (NUM_REGS),
        .SEL_W    (SEL_W)
    ) u_src_dec (
        .i_sel      (w_src_sel),
        .i_en       (w_src_en),
        .o_onehot   (w_src_oh),
        .o_in_range (w_src_in_range)
    );

    bus_index_decoder #(
        .NUM_REGS (NUM_REGS),
        .SEL_W    (SEL_W)
    ) u_dst_dec (
        .i_sel      (w_dst_sel),
        .i_en       (w_dst_en),
        .o_onehot   (w_dst_oh),
        .o_in_range (w_dst_in_range)
    );

    assign w_reject = (op_uses_src(CMD_OP) && !w_src_in_range)
                   || (op_uses_dst(CMD_OP) && !w_dst_in_range)
                   || ((CMD_OP == OP_MOVE) && (CMD_SRC == CMD_DST));

    // State register
    always_ff @(posedge CLOCK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process evaluation order.
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_op  <= OP_MOVE;
            r_src <= '0;
            r_dst <= '0;
            r_imm <= '0;
        end else if (w_accept) begin
            r_op  <= CMD_OP;
            r_src <= CMD_SRC;
            r_dst <= CMD_DST;
            r_imm <= CMD_IMM;
        end
    end

    // An interrupted READ leaves RDATA alone: reset wins over the capture.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_rdata <= '0;
        end else if ((r_state == ST_LATCH) && (r_op == OP_READ)) begin
            r_rdata <= DATA;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_reject) begin
                        w_next_state = ST_ERR;
                    end else if (CMD_OP == OP_INC) begin
                        w_next_state = ST_INC;
                    end else begin
                        w_next_state = ST_SETUP;
                    end
                end
            end
            ST_SETUP: w_next_state = ST_LATCH;
            ST_LATCH: w_next_state = (r_op == OP_READ) ? ST_RDONE : ST_IDLE;
            ST_INC:   w_next_state = ST_IDLE;
            ST_ERR:   w_next_state = ST_IDLE;
            ST_RDONE: w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        w_dst_wr_oh  = (r_state == ST_LATCH) ? w_dst_oh : '0;
        ENABLE       = w_src_oh | w_dst_wr_oh;
        RW           = IDLE_RW[NUM_REGS-1:0] & ~w_dst_wr_oh;
        COUNT        = (r_state == ST_INC) ? w_dst_oh : '0;
        CMD_READY    = w_idle && !RESET;
        RDATA_VALID  = (r_state == ST_RDONE);
        ERROR        = (r_state == ST_ERR);
        w_drive_data = ((r_state == ST_SETUP) || (r_state == ST_LATCH)) && (r_op == OP_LOAD_IMM);
    end

    assign DATA  = w_drive_data ? r_imm : 'z;
    assign RDATA = r_rdata;

    a_single_writer: assert property (@(posedge CLOCK) $countones(ENABLE & ~RW) <= 1);
    a_single_driver: assert property (@(posedge CLOCK)
        ($countones(ENABLE & RW) + (w_drive_data ? 1 : 0)) <= 1);
    a_count_alone:   assert property (@(posedge CLOCK) !((|COUNT) && (|ENABLE)));
    a_rw_when_off:   assert property (@(posedge CLOCK) (~ENABLE & ~RW) == '0);

endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: a behavioural register bank on the
// bus, plus a per-cycle expectation queue filled when each command is issued.
module tb_bus_sequencer;
    import bat_bus_pkg::*;

    localparam int BW = 16;
    localparam int NR = 8;
    localparam int SW = 4;   // one spare index bit so indices >= NUM_REGS can be issued

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [SW-1:0] cmd_src;
    logic [SW-1:0] cmd_dst;
    logic [BW-1:0] cmd_imm;
    logic [NR-1:0] enable;
    logic [NR-1:0] rw;
    logic [NR-1:0] count;
    logic [BW-1:0] rdata;
    logic          rdata_valid;
    logic          error;
    tri0  [BW-1:0] data_bus;   // undriven bus reads as 0

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_sequencer #(
        .BUS_WIDTH (BW),
        .NUM_REGS  (NR),
        .SEL_W     (SW)
    ) dut (
        .CLOCK       (clk),
        .RESET       (rst),
        .CMD_VALID   (cmd_valid),
        .CMD_READY   (cmd_ready),
        .CMD_OP      (cmd_op),
        .CMD_SRC     (cmd_src),
        .CMD_DST     (cmd_dst),
        .CMD_IMM     (cmd_imm),
        .ENABLE      (enable),
        .RW          (rw),
        .COUNT       (count),
        .DATA        (data_bus),
        .RDATA       (rdata),
        .RDATA_VALID (rdata_valid),
        .ERROR       (error)
    );

    // Behavioural bus registers
    logic [BW-1:0] reg_file [NR];
    logic          env_load;
    logic          drv_en;
    logic [BW-1:0] drv_val;

    function automatic logic [BW-1:0] init_val(input int i);
        case (i)
            2:       return 16'h1234;
            3:       return 16'h00FF;
            7:       return 16'h00A5;
            default: return 16'h4000 | BW'(i);
        endcase
    endfunction

    always_comb begin
        drv_en  = 1'b0;
        drv_val = '0;
        for (int i = 0; i < NR; i++) begin
            if (enable[i] && rw[i]) begin
                drv_en  = 1'b1;
                drv_val = reg_file[i];
            end
        end
    end

    assign data_bus = drv_en ? drv_val : 'z;

    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (env_load)                   reg_file[i] <= init_val(i);
            else if (enable[i] && !rw[i])   reg_file[i] <= data_bus;
            else if (count[i])              reg_file[i] <= reg_file[i] + 1'b1;
        end
    end

    // Expectation scoreboard
    typedef struct packed {
        logic [NR-1:0] en;
        logic [NR-1:0] rw;
        logic [NR-1:0] cnt;
        logic          ready;
        logic          err;
        logic          rv;
        logic          chk_data;
        logic [BW-1:0] data;
        logic [BW-1:0] rdata;
    } exp_t;

    exp_t          exp_q [$];
    string         tag_q [$];
    int            inc_cycs [$];
    logic [BW-1:0] model_regs [NR];
    logic [BW-1:0] exp_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void push_rec(input string tag, input logic [NR-1:0] en, input logic [NR-1:0] rwv,
                                     input logic [NR-1:0] cnt, input logic ready, input logic err,
                                     input logic rv, input logic [BW-1:0] data, input logic [BW-1:0] rd);
        exp_t r;
        r.en = en; r.rw = rwv; r.cnt = cnt; r.ready = ready; r.err = err; r.rv = rv;
        r.chk_data = 1'b1; r.data = data; r.rdata = rd;
        exp_q.push_back(r);
        tag_q.push_back(tag);
    endfunction

    task automatic compare_rec(input string tag, input exp_t r);
        check({tag, "/enable"}, enable, r.en);
        check({tag, "/rw"}, rw, r.rw);
        check({tag, "/count"}, count, r.cnt);
        check({tag, "/ready"}, cmd_ready, r.ready);
        check({tag, "/error"}, error, r.err);
        check({tag, "/rvalid"}, rdata_valid, r.rv);
        check({tag, "/rdata"}, rdata, r.rdata);
        if (r.chk_data) check({tag, "/data"}, data_bus, r.data);
        if (r.cnt != '0) inc_cycs.push_back(cyc);
    endtask

    // Issue one command from a negedge with the DUT idle; returns at the negedge
    // of the first idle cycle. reset_at > 0 raises RESET after that record.
    task automatic issue(input logic [1:0] op, input logic [SW-1:0] src, input logic [SW-1:0] dst,
                         input logic [BW-1:0] imm, input int reset_at);
        exp_t          r;
        string         t;
        int            n;
        int            done_k;
        logic          rej;
        logic [NR-1:0] s_oh;
        logic [NR-1:0] d_oh;
        logic [BW-1:0] sv;
        logic [BW-1:0] ones;

        n = 0;
        while (!cmd_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_cmd", cmd_ready, 1);

        cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_imm = imm;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_op = ~op; cmd_src = ~src; cmd_dst = ~dst; cmd_imm = ~imm;

        rej  = ((op == OP_MOVE || op == OP_READ) && src >= NR)
            || ((op != OP_READ) && dst >= NR)
            || (op == OP_MOVE && src == dst);
        s_oh = (src < NR) ? (NR'(1) << src) : '0;
        d_oh = (dst < NR) ? (NR'(1) << dst) : '0;
        sv   = (src < NR) ? model_regs[int'(src)] : '0;
        ones = '1;

        if (rej) begin
            push_rec("rej_err", '0, ones, '0, 0, 1, 0, '0, exp_rdata);
            push_rec("rej_idle", '0, ones, '0, 1, 0, 0, '0, exp_rdata);
        end else begin
            case (op)
                OP_MOVE: begin
                    push_rec("move_setup", s_oh, ones, '0, 0, 0, 0, sv, exp_rdata);
                    push_rec("move_latch", s_oh | d_oh, ~d_oh, '0, 0, 0, 0, sv, exp_rdata);
                    push_rec("move_idle", '0, ones, '0, 1, 0, 0, '0, exp_rdata);
                end
                OP_LOAD_IMM: begin
                    push_rec("load_setup", '0, ones, '0, 0, 0, 0, imm, exp_rdata);
                    push_rec("load_latch", d_oh, ~d_oh, '0, 0, 0, 0, imm, exp_rdata);
                    push_rec("load_idle", '0, ones, '0, 1, 0, 0, '0, exp_rdata);
                end
                OP_READ: begin
                    push_rec("read_setup", s_oh, ones, '0, 0, 0, 0, sv, exp_rdata);
                    push_rec("read_latch", s_oh, ones, '0, 0, 0, 0, sv, exp_rdata);
                    push_rec("read_done", '0, ones, '0, 0, 0, 1, '0, sv);
                    push_rec("read_idle", '0, ones, '0, 1, 0, 0, '0, sv);
                end
                default: begin
                    push_rec("inc_pulse", '0, ones, d_oh, 0, 0, 0, '0, exp_rdata);
                    push_rec("inc_idle", '0, ones, '0, 1, 0, 0, '0, exp_rdata);
                end
            endcase
        end

        done_k = 99;
        for (int k = 1; exp_q.size() > 0; k++) begin
            @(negedge clk);
            r = exp_q.pop_front();
            t = tag_q.pop_front();
            compare_rec(t, r);
            if (k == reset_at) begin
                rst    = 1'b1;
                done_k = k;
                exp_q.delete();
                tag_q.delete();
                break;
            end
        end

        // A reset raised after record k still lets the edge ending that cycle act.
        if (!rej) begin
            case (op)
                OP_MOVE:     if (done_k >= 2) model_regs[int'(dst)] = sv;
                OP_LOAD_IMM: if (done_k >= 2) model_regs[int'(dst)] = imm;
                OP_READ:     if (done_k >= 3) exp_rdata = sv;
                default:     if (done_k >= 1) model_regs[int'(dst)] = model_regs[int'(dst)] + 1'b1;
            endcase
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst = 1'b1; env_load = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_src = '0; cmd_dst = '0; cmd_imm = '0;
        for (int i = 0; i < NR; i++) model_regs[i] = init_val(i);
        exp_rdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset/enable", enable, 8'h00);
        check("reset/rw", rw, 8'hFF);
        check("reset/count", count, 8'h00);
        check("reset/ready", cmd_ready, 0);
        check("reset/rdata", rdata, 16'h0000);
        check("reset/rvalid", rdata_valid, 0);
        check("reset/error", error, 0);
        check("reset/data", data_bus, 16'h0000);
        rst = 1'b0; env_load = 1'b0;

        issue(OP_MOVE, 4'd2, 4'd5, 16'h0000, 0);
        issue(OP_LOAD_IMM, 4'd0, 4'd0, 16'hBEEF, 0);
        issue(OP_READ, 4'd7, 4'd0, 16'h0000, 0);
        check("read7_rdata", rdata, 16'h00A5);
        issue(OP_MOVE, 4'd2, 4'd6, 16'h0000, 0);

        issue(OP_INC, 4'd0, 4'd3, 16'h0000, 0);
        check("inc3_first", reg_file[3], 16'h0100);
        issue(OP_INC, 4'd0, 4'd3, 16'h0000, 0);
        if (inc_cycs.size() == 2) check("inc_spacing", inc_cycs[1] - inc_cycs[0], 2);
        else check("inc_pulse_count", inc_cycs.size(), 2);

        issue(OP_MOVE, 4'd4, 4'd4, 16'h0000, 0);
        issue(OP_INC, 4'd0, 4'd8, 16'h0000, 0);
        issue(OP_READ, 4'd9, 4'd1, 16'h0000, 0);
        issue(OP_LOAD_IMM, 4'd0, 4'd12, 16'h5A5A, 0);

        issue(OP_READ, 4'd5, 4'd0, 16'h0000, 0);
        check("read5_rdata", rdata, 16'h1234);

        // Reset during SETUP of a MOVE, with a fresh command offered during reset
        issue(OP_MOVE, 4'd1, 4'd6, 16'h0000, 1);
        cmd_valid = 1'b1; cmd_op = OP_MOVE; cmd_src = 4'd2; cmd_dst = 4'd4;
        @(negedge clk);
        exp_rdata = '0;
        check("rst_setup/enable", enable, 8'h00);
        check("rst_setup/rw", rw, 8'hFF);
        check("rst_setup/count", count, 8'h00);
        check("rst_setup/ready", cmd_ready, 0);
        check("rst_setup/rdata", rdata, exp_rdata);
        check("rst_setup/data", data_bus, 16'h0000);
        @(negedge clk);
        check("rst_valid/enable", enable, 8'h00);
        check("rst_valid/ready", cmd_ready, 0);
        rst = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        check("rst_release/ready", cmd_ready, 1);
        check("rst_release/enable", enable, 8'h00);
        check("rst_setup/dst6", reg_file[6], model_regs[6]);
        check("rst_valid/dst4", reg_file[4], model_regs[4]);

        // Reset at the edge ending LATCH: destination capture still happens
        issue(OP_MOVE, 4'd0, 4'd1, 16'h0000, 2);
        @(negedge clk);
        check("rst_latch/enable", enable, 8'h00);
        check("rst_latch/ready", cmd_ready, 0);
        check("rst_latch/dst1", reg_file[1], 16'hBEEF);
        rst = 1'b0;
        @(negedge clk);
        check("rst_latch_release/ready", cmd_ready, 1);

        issue(OP_READ, 4'd1, 4'd0, 16'h0000, 0);
        check("read1_rdata", rdata, 16'hBEEF);

        for (int i = 0; i < NR; i++) begin
            check($sformatf("final_reg%0d", i), reg_file[i], model_regs[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bus_sequencer.md
Name: bus_sequencer

Overview:
- Bus initiator for the shared bidirectional data bus of the Bat Amateur processor.
- Accepts one command at a time over a valid/ready handshake: register move, immediate load, register read-back or register increment.
- Generates the per-register ENABLE/RW/COUNT strobes that bus registers respond to. Drives DATA itself only for immediate loads.
- Sits between the instruction decode logic and the bank of bus registers.

Parameters:
- BUS_WIDTH, 16: width of the DATA bus, CMD_IMM and RDATA.
- NUM_REGS, 8: number of attached bus registers. Legal range is 2..16.
- SEL_W, $clog2(NUM_REGS): width of the register index fields.

Ports:
- CLOCK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  synchronous reset, active-high.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  sequencer can accept a command.
- CMD_OP  in  2  opcode: 0=MOVE, 1=LOAD_IMM, 2=READ, 3=INC.
- CMD_SRC  in  SEL_W  source register index (MOVE, READ).
- CMD_DST  in  SEL_W  destination register index (MOVE, LOAD_IMM, INC).
- CMD_IMM  in  BUS_WIDTH  immediate value for LOAD_IMM.
- ENABLE  out  NUM_REGS  per-register bus enable, active-high.
- RW  out  NUM_REGS  per-register direction: 1 = register drives bus, 0 = register latches bus.
- COUNT  out  NUM_REGS  per-register increment strobe.
- DATA  inout  BUS_WIDTH  shared bus. Driven only in LOAD_IMM states, otherwise high-Z.
- RDATA  out  BUS_WIDTH  value captured by the last READ.
- RDATA_VALID  out  1  one-cycle pulse when RDATA updates.
- ERROR  out  1  one-cycle pulse on a rejected command.

Behaviour:
- Outputs and state reset: all of ENABLE/RW/COUNT/RDATA/RDATA_VALID/ERROR/CMD_READY/DATA are registered or decoded from registered state.
- Reset values: state IDLE, ENABLE=0, RW=all 1s, COUNT=0, DATA=Z, RDATA=0, RDATA_VALID=0, ERROR=0, CMD_READY=0 while RESET is high.
- Handshake: CMD_READY=1 only in IDLE with RESET low. A command is accepted on a rising edge with CMD_VALID&&CMD_READY. All command fields are latched at acceptance and ignored afterwards.
- States: IDLE, SETUP, LATCH, INC, ERR, RDONE.
- Rejection check at acceptance: any used index >= NUM_REGS, or MOVE with SRC==DST.
  - Rejected command goes to ERR: ERROR=1 for one cycle, no strobes, then IDLE.
- MOVE:
  - SETUP: ENABLE[src]=1, RW[src]=1.
  - LATCH: ENABLE[src]=1, RW[src]=1, ENABLE[dst]=1, RW[dst]=0. Dst captures at the end of LATCH.
  - Then IDLE.
- LOAD_IMM:
  - SETUP: DATA=imm, all ENABLE=0.
  - LATCH: DATA=imm, ENABLE[dst]=1, RW[dst]=0.
  - Then IDLE, with DATA released to Z in the same cycle the state returns to IDLE.
- READ:
  - SETUP and LATCH both assert ENABLE[src]=1, RW[src]=1.
  - The sequencer samples DATA into RDATA at the end of LATCH.
  - RDONE: RDATA_VALID=1 for one cycle, then IDLE.
- INC: INC state asserts COUNT[dst]=1 with all ENABLE=0 for exactly one cycle, then IDLE.
- Latency, accept edge to next CMD_READY: MOVE/LOAD_IMM 3 cycles, READ 4, INC 2, rejected 2.
- Invariants:
  - At most one bus driver (a register or the sequencer) in any cycle.
  - At most one ENABLE with RW=0 in any cycle.
  - COUNT is never asserted together with any ENABLE.
  - RW is 1 for every non-enabled register.
- RDATA holds its value until the next READ completes.
- Reset mid-operation: on the edge with RESET sampled high, all outputs go to their reset values and state goes to IDLE.
  - If that edge ends a LATCH cycle, the destination capture on that edge still happens; it is not suppressed.
  - RDATA/RDATA_VALID of an interrupted READ are not updated.
- Simultaneous CMD_VALID with RESET: the command is not accepted.

Decomposition:
- Shared package bat_bus_pkg:
  - Opcode constants OP_MOVE/OP_LOAD_IMM/OP_READ/OP_INC.
  - State encoding enum for the sequencer.
  - Constant IDLE_RW (all 1s).
- One sub-module, bus_index_decoder: SEL_W index plus enable in, NUM_REGS one-hot out plus an in_range flag. Instantiated twice (src, dst).

Test Plan:
- MOVE src=2 dst=5, reg2=0x1234 → cycle+1 ENABLE=0x04 RW[2]=1; cycle+2 ENABLE=0x24 RW[5]=0; reg5=0x1234 after; CMD_READY back high at cycle+3.
- LOAD_IMM dst=0 imm=0xBEEF → DATA=0xBEEF in SETUP and LATCH only, Z otherwise; reg0=0xBEEF; no register ever drives in those cycles.
- READ src=7, reg7=0x00A5 → RDATA=0x00A5 and RDATA_VALID=1 for exactly one cycle at accept+3; RDATA unchanged by a following MOVE.
- INC dst=3, reg3=0x00FF → COUNT=0x08 for one cycle with ENABLE=0; reg3=0x0100; back-to-back INC commands give COUNT pulses 2 cycles apart.
- MOVE src=4 dst=4, then INC dst=8 with NUM_REGS=8 → ERROR pulses once each; ENABLE/COUNT stay 0; no register value changes.
- RESET high during SETUP of a MOVE → next cycle ENABLE=0, RW=all 1s, DATA=Z, CMD_READY=0; after RESET drops, CMD_READY=1 and the dst value is unchanged.
